// File: rtl/perspective_divide.sv
// Clip-space to NDC stage: divides x, y, z by w with one shared restoring divider.
// Optional macro PDIV_CLIP_EN enables the view-volume clip flag.
module perspective_divide #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] vec_in [3:0],
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] ndc_out [2:0],
    output logic             div_zero_out,
    output logic             clipped_out
);
    localparam int DW = WIDTH + FRAC_BITS;
    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0]    LAST    = CW'(DW - 1);
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [DW-1:0]    MAX_MAG = {{FRAC_BITS{1'b0}}, MAX_POS};

    typedef enum logic [2:0] {IDLE, DIV_X, DIV_Y, DIV_Z, DONE} state_t;

    // Unsigned magnitude of a signed value; -2^(WIDTH-1) maps to 2^(WIDTH-1) exactly.
    function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [DW-1:0] dividend(input logic [WIDTH-1:0] num);
        return {abs_mag(num), {FRAC_BITS{1'b0}}};
    endfunction

    function automatic logic [WIDTH-1:0] sat_result(input logic [DW-1:0] quo,
                                                    input logic [WIDTH-1:0] num,
                                                    input logic w_zero,
                                                    input logic neg);
        logic [WIDTH-1:0] mag;
        logic             neg_eff;
        neg_eff = neg;
        if (w_zero) begin
            mag     = (num == '0) ? '0 : MAX_POS;
            neg_eff = num[WIDTH-1];
        end else if (quo > MAX_MAG) begin
            mag = MAX_POS;
        end else begin
            mag = quo[WIDTH-1:0];
        end
        return neg_eff ? (~mag + 1'b1) : mag;
    endfunction

`ifdef PDIV_CLIP_EN
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-FRAC_BITS-1){1'b0}}, 1'b1, {FRAC_BITS{1'b0}}};

    function automatic logic exceeds_one(input logic [WIDTH-1:0] v);
        return abs_mag(v) > ONE;
    endfunction
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] ndc_q [2:0];
    logic [WIDTH-1:0] ndc_d [2:0];
    logic             div_zero_q, div_zero_d;
`ifdef PDIV_CLIP_EN
    logic             clipped_q, clipped_d;
`endif

    logic [WIDTH-1:0] vec_q [3:0];
    logic [WIDTH-1:0] vec_d [3:0];
    logic [WIDTH-1:0] rem_q, rem_d, res_x_q, res_x_d, res_y_q, res_y_d;
    logic [DW-1:0]    quo_q, quo_d;

    logic [WIDTH-1:0] div_mag, cur_num, rem_step, comp_res;
    logic [WIDTH:0]   rem_sh;
    logic [DW-1:0]    quo_step;
    logic             w_zero, q_bit;

    // Control and visible outputs: asynchronous reset aborts any division in flight.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ndc_q      <= '{default: '0};
            div_zero_q <= 1'b0;
`ifdef PDIV_CLIP_EN
            clipped_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ndc_q      <= ndc_d;
            div_zero_q <= div_zero_d;
`ifdef PDIV_CLIP_EN
            clipped_q  <= clipped_d;
`endif
        end
    end

    always_ff @(posedge clk_in) begin
        vec_q   <= vec_d;
        rem_q   <= rem_d;
        quo_q   <= quo_d;
        res_x_q <= res_x_d;
        res_y_q <= res_y_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (valid_in) begin
                state_d = DIV_X;
                cnt_d   = '0;
            end
            DIV_X, DIV_Y, DIV_Z: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (state_q == DIV_X)      state_d = DIV_Y;
                    else if (state_q == DIV_Y) state_d = DIV_Z;
                    else                       state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: if (ready_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_out = (state_q == IDLE);
        valid_out = (state_q == DONE);
    end

    // One restoring-division step per cycle; the last step of each component is
    // consumed directly from the combinational result on the state-advancing edge.
    always_comb begin
        vec_d      = vec_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        res_x_d    = res_x_q;
        res_y_d    = res_y_q;
        ndc_d      = ndc_q;
        div_zero_d = div_zero_q;
`ifdef PDIV_CLIP_EN
        clipped_d  = clipped_q;
`endif
        w_zero   = (vec_q[3] == '0);
        div_mag  = abs_mag(vec_q[3]);
        cur_num  = (state_q == DIV_X) ? vec_q[0] : (state_q == DIV_Y) ? vec_q[1] : vec_q[2];
        rem_sh   = {rem_q, quo_q[DW-1]};
        q_bit    = (rem_sh >= {1'b0, div_mag});
        rem_step = q_bit ? (rem_sh[WIDTH-1:0] - div_mag) : rem_sh[WIDTH-1:0];
        quo_step = {quo_q[DW-2:0], q_bit};
        comp_res = sat_result(quo_step, cur_num, w_zero, cur_num[WIDTH-1] ^ vec_q[3][WIDTH-1]);

        if (state_q == IDLE && valid_in) begin
            vec_d = vec_in;
            rem_d = '0;
            quo_d = dividend(vec_in[0]);
        end else if (state_q == DIV_X || state_q == DIV_Y || state_q == DIV_Z) begin
            rem_d = rem_step;
            quo_d = quo_step;
            if (cnt_q == LAST) begin
                rem_d = '0;
                if (state_q == DIV_X) begin
                    res_x_d = comp_res;
                    quo_d   = dividend(vec_q[1]);
                end else if (state_q == DIV_Y) begin
                    res_y_d = comp_res;
                    quo_d   = dividend(vec_q[2]);
                end else begin
                    ndc_d[0]   = res_x_q;
                    ndc_d[1]   = res_y_q;
                    ndc_d[2]   = comp_res;
                    div_zero_d = w_zero;
`ifdef PDIV_CLIP_EN
                    clipped_d  = vec_q[3][WIDTH-1] || w_zero || exceeds_one(res_x_q)
                                 || exceeds_one(res_y_q) || exceeds_one(comp_res);
`endif
                end
            end
        end
    end

    assign ndc_out[0]   = ndc_q[0];
    assign ndc_out[1]   = ndc_q[1];
    assign ndc_out[2]   = ndc_q[2];
    assign div_zero_out = div_zero_q;
`ifdef PDIV_CLIP_EN
    assign clipped_out  = clipped_q;
`else
    assign clipped_out  = 1'b0;
`endif
endmodule

// File: tb/tb_perspective_divide.sv
// Directed bench for perspective_divide: scoreboard of expected NDC results, fixed 144-cycle latency.
module tb_perspective_divide;
    localparam int W = 32;
    localparam int LAT = 144;

    logic         clk_in = 1'b0;
    logic         rst_in, valid_in, ready_out, valid_out, ready_in, div_zero_out, clipped_out;
    logic [W-1:0] vec_in [3:0];
    logic [W-1:0] ndc_out [2:0];

    typedef struct packed {
        logic [2:0][W-1:0] ndc;
        logic              dz;
        logic              clip;
    } exp_t;

    exp_t sb[$];
    exp_t last_e;
    int   errors = 0;
    int   checks = 0;

    perspective_divide dut (
        .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .ready_out(ready_out),
        .vec_in(vec_in), .valid_out(valid_out), .ready_in(ready_in), .ndc_out(ndc_out),
        .div_zero_out(div_zero_out), .clipped_out(clipped_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, req);
        end
    endtask

    function automatic logic [W-1:0] ref_q(input logic [W-1:0] n, input logic [W-1:0] w);
        longint an, aw, q;
        if (w == 0) begin
            if (n == 0) return 0;
            return n[W-1] ? 32'h8000_0001 : 32'h7FFF_FFFF;
        end
        an = longint'($signed(n));
        aw = longint'($signed(w));
        if (an < 0) an = -an;
        if (aw < 0) aw = -aw;
        q = (an * 65536) / aw;
        if (q > 64'h7FFF_FFFF) q = 64'h7FFF_FFFF;
        if (n[W-1] ^ w[W-1]) q = -q;
        return q[W-1:0];
    endfunction

    function automatic exp_t model(input logic [W-1:0] x, y, z, w);
        exp_t   e;
        longint a;
        e.ndc[0] = ref_q(x, w);
        e.ndc[1] = ref_q(y, w);
        e.ndc[2] = ref_q(z, w);
        e.dz     = (w == 0);
        e.clip   = 1'b0;
`ifdef PDIV_CLIP_EN
        if ($signed(w) <= 0 || e.dz) e.clip = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = longint'($signed(e.ndc[i]));
            if (a < 0) a = -a;
            if (a > 65536) e.clip = 1'b1;
        end
`endif
        return e;
    endfunction

    // Called one time unit after a rising edge.
    task automatic send(input logic [W-1:0] x, y, z, w);
        check("ready_before_accept", ready_out, 1);
        vec_in[0] = x; vec_in[1] = y; vec_in[2] = z; vec_in[3] = w;
        valid_in  = 1'b1;
        @(posedge clk_in); #1;
        valid_in = 1'b0;
        sb.push_back(model(x, y, z, w));
        check("ready_low_busy", ready_out, 0);
    endtask

    task automatic collect(input string tag);
        int lat;
        bit seen;
        lat  = 0;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(posedge clk_in); #1;
            lat++;
            if (valid_out) seen = 1;
        end
        check({tag, "_latency"}, lat, LAT);
        if (sb.size() > 0) begin
            last_e = sb.pop_front();
            check({tag, "_ndc_x"}, ndc_out[0], last_e.ndc[0]);
            check({tag, "_ndc_y"}, ndc_out[1], last_e.ndc[1]);
            check({tag, "_ndc_z"}, ndc_out[2], last_e.ndc[2]);
            check({tag, "_div_zero"}, div_zero_out, last_e.dz);
            check({tag, "_clipped"}, clipped_out, last_e.clip);
        end
    endtask

    task automatic handshake(input string tag);
        ready_in = 1'b1;
        @(posedge clk_in); #1;
        ready_in = 1'b0;
        check({tag, "_valid_cleared"}, valid_out, 0);
        check({tag, "_ready_restored"}, ready_out, 1);
        check({tag, "_ndc_x_retained"}, ndc_out[0], last_e.ndc[0]);
    endtask

    initial begin
        rst_in   = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b0;
        for (int i = 0; i < 4; i++) vec_in[i] = '0;
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_ready", ready_out, 1);
        check("rst_valid", valid_out, 0);
        check("rst_ndc_x", ndc_out[0], 0);
        check("rst_ndc_y", ndc_out[1], 0);
        check("rst_ndc_z", ndc_out[2], 0);
        check("rst_div_zero", div_zero_out, 0);
        check("rst_clipped", clipped_out, 0);
        rst_in = 1'b0;
        @(posedge clk_in); #1;

        send(32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000, 32'h0002_0000);
        collect("nominal");
        check("nominal_const_x", ndc_out[0], 32'h0001_0000);
        check("nominal_const_y", ndc_out[1], 32'hFFFF_8000);
        check("nominal_const_z", ndc_out[2], 32'h0000_4000);
        handshake("nominal");

        send(32'h0001_0000, 32'hFFFF_0000, 32'h0000_0000, 32'h0000_0000);
        collect("divzero");
        check("divzero_const_y", ndc_out[1], 32'h8000_0001);
        handshake("divzero");

        send(32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0003, 32'h0000_0001);
        collect("saturate");
        check("saturate_const_z", ndc_out[2], 32'h0003_0000);
        handshake("saturate");

        // Backpressure: hold ready_in low while upstream keeps offering vectors.
        send(32'hFFFD_0000, 32'h0001_0000, 32'h0001_8000, 32'h0004_0000);
        collect("bp");
        for (int i = 0; i < 10; i++) begin
            valid_in = 1'b1;
            for (int k = 0; k < 4; k++) vec_in[k] = $urandom();
            @(posedge clk_in); #1;
            check("bp_valid_held", valid_out, 1);
            check("bp_ready_low", ready_out, 0);
            check("bp_ndc_y_held", ndc_out[1], last_e.ndc[1]);
        end
        valid_in = 1'b0;
        handshake("bp");
        repeat (3) @(posedge clk_in);
        #1;
        check("bp_no_extra_accept", ready_out, 1);

        // Asynchronous reset 50 cycles into the first division.
        send(32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000, 32'h0002_0000);
        repeat (50) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        #1;
        check("midrst_ready", ready_out, 1);
        check("midrst_valid", valid_out, 0);
        check("midrst_ndc_x", ndc_out[0], 0);
        check("midrst_ndc_z", ndc_out[2], 0);
        check("midrst_div_zero", div_zero_out, 0);
        sb.delete();
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        @(posedge clk_in); #1;
        send(32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000, 32'h0002_0000);
        collect("after_rst");
        handshake("after_rst");

        send(32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000, 32'hFFFF_0000);
        collect("neg_w");
        handshake("neg_w");

        send(32'h0003_0000, 32'h0000_0000, 32'h0000_0000, 32'h0002_0000);
        collect("outside");
        handshake("outside");

        for (int r = 0; r < 3; r++) begin
            send($urandom(), $urandom(), $urandom_range(65535, 0), $urandom());
            collect("random");
            handshake("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
